gnrl_rr_burst_arb: RTL
======================

Name: gnrl_rr_burst_arb

Overview:
- Round-robin arbiter that shares one downstream valid/ready port among N burst requesters.
- Typical shared resource: a register-file write port or a memory request channel.
- Grant is registered and locked for a whole burst, up to and including the beat with last=1. Priority then rotates.
- Grant and pointer state use load-enabled flops. They update only on arbitration or burst completion.

Parameters:
- N, 4, number of requesters (≥1).
- DW, 32, payload width per requester.
- IW, (N>1 ? $clog2(N) : 1), width of the requester index; derived, not overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  N  per-requester beat valid.
- req_last  input  N  per-requester last-beat flag.
- req_data  input  N*DW  requester i's payload in bits [i*DW +: DW].
- req_ready  output  N  per-requester beat accept.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  DW  payload of the granted requester.
- out_last  output  1  last flag of the granted requester.
- out_id  output  IW  index of the granted requester.
- busy  output  1  high while in BUSY.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state is sampled at the rising edge of clk while rst=1.
- Reset state: state=IDLE, ptr=0, gnt_id=0. Outputs: req_ready=0, out_valid=0, out_data=0, out_last=0, out_id=0, busy=0.
- States: IDLE and BUSY.
- IDLE:
  - All outputs are 0 (out_data, out_last and out_id are forced to 0).
  - If req_valid≠0, the winner is the first set bit scanning ptr, ptr+1, … N-1, 0, … ptr-1.
  - Next edge: gnt_id←winner, state←BUSY.
  - Arbitration latency: 1 cycle from valid to grant. No beat is transferred in the arbitration cycle.
- BUSY:
  - out_valid=req_valid[gnt_id], out_data=req_data[gnt_id], out_last=req_last[gnt_id], out_id=gnt_id, busy=1.
  - req_ready[gnt_id]=out_ready; all other req_ready bits are 0. The path is combinational: zero added latency per beat.
  - Beat transfer occurs when out_valid & out_ready.
  - Transfer with out_last=1: next edge state←IDLE, ptr←(gnt_id==N-1)?0:gnt_id+1.
  - Transfer with out_last=0: stay in BUSY; gnt_id and ptr unchanged.
- Mid-burst gap: if the granted requester drops valid, out_valid=0 and the grant is held. There is no timeout and no preemption.
- Requests from others while BUSY are ignored until return to IDLE. Those requesters see req_ready=0.
- Back-to-back bursts: after the last beat there is always one IDLE cycle before the next grant. Maximum throughput is one burst per (beats+1) cycles.
- Single-beat burst (valid & last on the first BUSY cycle with ready=1): exactly one BUSY cycle, then IDLE.
- Pointer wrap: the grant goes N-1 → ptr=0. With N=1 the ptr stays 0 and out_id=0.
- Reset during BUSY: the burst is abandoned, all state returns to reset values, and no handshake is generated on the reset cycle.
- rst has priority over every other condition in the same cycle.
- Data is never buffered. The block holds no payload and no flow-control credit.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=4'b1111 → all outputs 0 and busy=0 throughout. After release, ptr=0 so the first grant is out_id=0.
- Rotation: all four requesters post 1-beat bursts continuously with out_ready=1 → grant order 0,1,2,3,0. Each grant is separated by one IDLE cycle.
- Burst lock: req 1 sends 3 beats (D1=0xA1, 0xA2, 0xA3 with last) while req 2 is valid → out_data sequence A1, A2, A3 all with out_id=1. Then req 2 is granted, and req_ready[2] stays 0 until then.
- Backpressure and gap:
  - out_ready=0 for 3 cycles mid-burst → no transfer and out_data stable.
  - Req 0 drops valid for 2 cycles → out_valid=0 and gnt_id still 0.
- Wrap and skip: ptr=3 with req_valid=4'b0101 → grant 0, then ptr=1, then grant 2.
- Reset mid-burst: assert rst during beat 2 of 4 → next cycle IDLE with ptr=0. The next grant goes to the lowest-indexed valid requester.

Source files
------------

// File: rtl/gnrl_rr_burst_arb.sv
// Round-robin burst arbiter: one downstream valid/ready port shared by N requesters.
// A grant is held from arbitration through the beat flagged last, then priority rotates.
module gnrl_rr_burst_arb #(
  parameter int N  = 4,
  parameter int DW = 32,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N-1:0]      req_last,
  input  logic [N*DW-1:0]   req_data,
  output logic [N-1:0]      req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic [IW-1:0]     out_id,
  output logic              busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_id;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   ptr_next;
  logic            found;
  logic            active;
  logic            burst_done;

  // Scan requesters starting at ptr, wrapping past N-1 back to 0.
  always_comb begin
    winner   = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IW'((int'(ptr) + k) % N);
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Reset masks the datapath so no handshake can occur in a reset cycle.
  assign active = (state == BUSY) && !rst;

  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_id    = '0;
    busy      = 1'b0;
    if (active) begin
      out_valid         = req_valid[gnt_id];
      out_data          = req_data[int'(gnt_id)*DW +: DW];
      out_last          = req_last[gnt_id];
      out_id            = gnt_id;
      busy              = 1'b1;
      req_ready[gnt_id] = out_ready;
    end
  end

  assign burst_done = out_valid && out_ready && out_last;
  assign ptr_next   = (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_id <= winner;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (burst_done) begin
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
